// File: rtl/cache_miss_controller.sv
// cache_miss_controller
//
// Sequences one CPU access at a time through a 4-way FIFO-replacement cache.
// The steps are tag lookup, optional victim flush, line fill from main memory,
// tag rewrite and CPU completion.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   cpu_req/we/addr     CPU access request; sampled only while IDLE
//   cpu_ready/cpu_hit   one-cycle completion pulse and its hit flag
//   tag_o/index_o       lookup key presented to the tag memory
//   rewrite_tag         one-cycle strobe that installs tag_o into the victim way
//   is_hit, need_use_fifo, channel, fifo_channel, fifo_tag_for_flush
//                       tag memory status (registered, valid in CHECK)
//   data_we/data_channel  data array write strobe and target way
//   mem_req/we/addr     main-memory line request, held until mem_ack
//   mem_ack             one-cycle main-memory acknowledge
//   hit_count, miss_count, flush_count  16-bit saturating statistics
//
// Optional feature: define CACHE_CTRL_STATS_EN to build the statistics
// counters. Without it the three counter ports are tied to zero.

module cache_miss_controller #(
  parameter int TAG_W    = 5,
  parameter int INDEX_W  = 7,
  parameter int OFFSET_W = 2,
  parameter int ADDR_W   = TAG_W + INDEX_W + OFFSET_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  output logic               cpu_ready,
  output logic               cpu_hit,
  output logic [TAG_W-1:0]   tag_o,
  output logic [INDEX_W-1:0] index_o,
  output logic               rewrite_tag,
  input  logic               is_hit,
  input  logic               need_use_fifo,
  input  logic [1:0]         channel,
  input  logic [1:0]         fifo_channel,
  input  logic [TAG_W-1:0]   fifo_tag_for_flush,
  output logic               data_we,
  output logic [1:0]         data_channel,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  output logic [15:0]        hit_count,
  output logic [15:0]        miss_count,
  output logic [15:0]        flush_count
);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    CHECK,
    FLUSH,
    FILL,
    UPDATE,
    RESPOND
  } state_t;

  state_t state;
  state_t next_state;

  logic               req_we;
  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_index;
  logic [1:0]         victim;
  logic [TAG_W-1:0]   victim_tag;
  logic               hit_flag;

  // The word offset only selects a word inside the line; line-granular
  // memory traffic never needs it.
  logic unused_offset;
  assign unused_offset = ^cpu_addr[OFFSET_W-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Request and victim latches. The tag memory answers one cycle after the
  // lookup, so its status is captured only in CHECK.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_we     <= 1'b0;
      req_tag    <= '0;
      req_index  <= '0;
      victim     <= '0;
      victim_tag <= '0;
      hit_flag   <= 1'b0;
    end else begin
      if (state == IDLE && cpu_req) begin
        req_we    <= cpu_we;
        req_tag   <= cpu_addr[ADDR_W-1 -: TAG_W];
        req_index <= cpu_addr[OFFSET_W +: INDEX_W];
      end
      if (state == CHECK) begin
        hit_flag <= is_hit;
        if (!is_hit) begin
          victim <= fifo_channel;
          if (need_use_fifo) begin
            victim_tag <= fifo_tag_for_flush;
          end
        end
      end
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cpu_req) next_state = LOOKUP;
      LOOKUP:  next_state = CHECK;
      CHECK: begin
        if (is_hit)             next_state = RESPOND;
        else if (need_use_fifo) next_state = FLUSH;
        else                    next_state = FILL;
      end
      FLUSH:   if (mem_ack) next_state = FILL;
      FILL:    if (mem_ack) next_state = UPDATE;
      UPDATE:  next_state = RESPOND;
      RESPOND: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode. A write hit stores in CHECK; a write miss stores again in
  // UPDATE on top of the freshly filled line.
  always_comb begin
    cpu_ready    = 1'b0;
    cpu_hit      = 1'b0;
    rewrite_tag  = 1'b0;
    data_we      = 1'b0;
    data_channel = 2'd0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    case (state)
      CHECK: begin
        if (is_hit && req_we) begin
          data_we      = 1'b1;
          data_channel = channel;
        end
      end
      FLUSH: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {victim_tag, req_index, {OFFSET_W{1'b0}}};
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_index, {OFFSET_W{1'b0}}};
        if (mem_ack) begin
          data_we      = 1'b1;
          data_channel = victim;
        end
      end
      UPDATE: begin
        rewrite_tag = 1'b1;
        if (req_we) begin
          data_we      = 1'b1;
          data_channel = victim;
        end
      end
      RESPOND: begin
        cpu_ready = 1'b1;
        cpu_hit   = hit_flag;
      end
      default: begin
      end
    endcase
  end

  assign tag_o   = req_tag;
  assign index_o = req_index;

`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
  logic [15:0] flush_cnt;

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      if (state == CHECK) begin
        if (is_hit) begin
          if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
        end else begin
          if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
        end
      end
      if (state == FLUSH && mem_ack && flush_cnt != 16'hFFFF) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end

  assign hit_count   = hit_cnt;
  assign miss_count  = miss_cnt;
  assign flush_count = flush_cnt;
`else
  assign hit_count   = 16'd0;
  assign miss_count  = 16'd0;
  assign flush_count = 16'd0;
`endif

endmodule

// File: tb/tb_cache_miss_controller.sv
// tb_cache_miss_controller
//
// Directed bench for cache_miss_controller. Inputs change on the falling
// edge and outputs are checked 1 time unit later, away from the rising edge.
// The tag memory is not modelled; each access drives its status inputs
// directly.

module tb_cache_miss_controller;

  localparam int TAG_W   = 5;
  localparam int INDEX_W = 7;
  localparam int ADDR_W  = 14;

  logic               clk;
  logic               reset;
  logic               cpu_req;
  logic               cpu_we;
  logic [ADDR_W-1:0]  cpu_addr;
  logic               cpu_ready;
  logic               cpu_hit;
  logic [TAG_W-1:0]   tag_o;
  logic [INDEX_W-1:0] index_o;
  logic               rewrite_tag;
  logic               is_hit;
  logic               need_use_fifo;
  logic [1:0]         channel;
  logic [1:0]         fifo_channel;
  logic [TAG_W-1:0]   fifo_tag_for_flush;
  logic               data_we;
  logic [1:0]         data_channel;
  logic               mem_req;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [15:0]        hit_count;
  logic [15:0]        miss_count;
  logic [15:0]        flush_count;

  int assert_count = 0;
  int fail_count   = 0;

  cache_miss_controller dut (
    .clk                (clk),
    .reset              (reset),
    .cpu_req            (cpu_req),
    .cpu_we             (cpu_we),
    .cpu_addr           (cpu_addr),
    .cpu_ready          (cpu_ready),
    .cpu_hit            (cpu_hit),
    .tag_o              (tag_o),
    .index_o            (index_o),
    .rewrite_tag        (rewrite_tag),
    .is_hit             (is_hit),
    .need_use_fifo      (need_use_fifo),
    .channel            (channel),
    .fifo_channel       (fifo_channel),
    .fifo_tag_for_flush (fifo_tag_for_flush),
    .data_we            (data_we),
    .data_channel       (data_channel),
    .mem_req            (mem_req),
    .mem_we             (mem_we),
    .mem_addr           (mem_addr),
    .mem_ack            (mem_ack),
    .hit_count          (hit_count),
    .miss_count         (miss_count),
    .flush_count        (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the CPU port.
  task automatic applyStimulus(input logic req, input logic we, input logic [ADDR_W-1:0] addr);
    cpu_req  = req;
    cpu_we   = we;
    cpu_addr = addr;
  endtask

  // One counted comparison.
  task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", name, observed, expected);
    end
  endtask

  // Everything that must read zero right after reset.
  task automatic checkQuiet(input string prefix);
    checkOutput({prefix, "_cpu_ready"}, 32'(cpu_ready), 32'd0);
    checkOutput({prefix, "_cpu_hit"}, 32'(cpu_hit), 32'd0);
    checkOutput({prefix, "_mem_req"}, 32'(mem_req), 32'd0);
    checkOutput({prefix, "_mem_we"}, 32'(mem_we), 32'd0);
    checkOutput({prefix, "_mem_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({prefix, "_tag_o"}, 32'(tag_o), 32'd0);
    checkOutput({prefix, "_index_o"}, 32'(index_o), 32'd0);
    checkOutput({prefix, "_rewrite_tag"}, 32'(rewrite_tag), 32'd0);
    checkOutput({prefix, "_data_we"}, 32'(data_we), 32'd0);
    checkOutput({prefix, "_hit_count"}, 32'(hit_count), 32'd0);
    checkOutput({prefix, "_miss_count"}, 32'(miss_count), 32'd0);
    checkOutput({prefix, "_flush_count"}, 32'(flush_count), 32'd0);
  endtask

`ifdef CACHE_CTRL_STATS_EN
  // One read hit to address 0, returning to IDLE.
  task automatic doHit();
    @(negedge clk); applyStimulus(1'b1, 1'b0, 14'h000); is_hit = 1'b1;
    @(negedge clk); applyStimulus(1'b0, 1'b0, 14'h000);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
  endtask
`endif

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, '0);
    is_hit = 1'b0;
    need_use_fifo = 1'b0;
    channel = 2'd0;
    fifo_channel = 2'd0;
    fifo_tag_for_flush = '0;
    mem_ack = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    checkQuiet("reset");
    @(negedge clk); reset = 1'b0; #1;
    checkOutput("idle_cpu_ready", 32'(cpu_ready), 32'd0);

    // 1: read miss on empty set, tag 0 index 1, fill acked in its 3rd cycle
    @(negedge clk); applyStimulus(1'b1, 1'b0, 14'h004);
    is_hit = 1'b0; need_use_fifo = 1'b0; fifo_channel = 2'd0; #1;
    @(negedge clk); applyStimulus(1'b0, 1'b0, 14'h004); #1;
    checkOutput("t1_lookup_tag", 32'(tag_o), 32'd0);
    checkOutput("t1_lookup_index", 32'(index_o), 32'd1);
    checkOutput("t1_lookup_mem_req", 32'(mem_req), 32'd0);
    @(negedge clk); #1;
    checkOutput("t1_check_mem_req", 32'(mem_req), 32'd0);
    checkOutput("t1_check_data_we", 32'(data_we), 32'd0);
    @(negedge clk); #1;
    checkOutput("t1_fill_mem_req", 32'(mem_req), 32'd1);
    checkOutput("t1_fill_mem_we", 32'(mem_we), 32'd0);
    checkOutput("t1_fill_mem_addr", 32'(mem_addr), 32'h004);
    checkOutput("t1_fill_data_we", 32'(data_we), 32'd0);
    @(negedge clk); #1;
    checkOutput("t1_fill2_mem_req", 32'(mem_req), 32'd1);
    @(negedge clk); mem_ack = 1'b1; #1;
    checkOutput("t1_ack_data_we", 32'(data_we), 32'd1);
    checkOutput("t1_ack_data_channel", 32'(data_channel), 32'd0);
    checkOutput("t1_ack_rewrite_tag", 32'(rewrite_tag), 32'd0);
    @(negedge clk); mem_ack = 1'b0; #1;
    checkOutput("t1_update_rewrite_tag", 32'(rewrite_tag), 32'd1);
    checkOutput("t1_update_data_we", 32'(data_we), 32'd0);
    checkOutput("t1_update_mem_req", 32'(mem_req), 32'd0);
    checkOutput("t1_update_cpu_ready", 32'(cpu_ready), 32'd0);
    @(negedge clk); #1;
    checkOutput("t1_respond_cpu_ready", 32'(cpu_ready), 32'd1);
    checkOutput("t1_respond_cpu_hit", 32'(cpu_hit), 32'd0);
    checkOutput("t1_respond_rewrite_tag", 32'(rewrite_tag), 32'd0);
    @(negedge clk); #1;
    checkOutput("t1_idle_cpu_ready", 32'(cpu_ready), 32'd0);

    // 2: same read, now a hit on channel 0; ready 3 cycles after sampling
    @(negedge clk); applyStimulus(1'b1, 1'b0, 14'h004); is_hit = 1'b1; channel = 2'd0; #1;
    @(negedge clk); applyStimulus(1'b0, 1'b0, 14'h004); #1;
    checkOutput("t2_c1_cpu_ready", 32'(cpu_ready), 32'd0);
    checkOutput("t2_c1_mem_req", 32'(mem_req), 32'd0);
    @(negedge clk); #1;
    checkOutput("t2_c2_cpu_ready", 32'(cpu_ready), 32'd0);
    checkOutput("t2_c2_mem_req", 32'(mem_req), 32'd0);
    checkOutput("t2_c2_data_we", 32'(data_we), 32'd0);
    @(negedge clk); #1;
    checkOutput("t2_c3_cpu_ready", 32'(cpu_ready), 32'd1);
    checkOutput("t2_c3_cpu_hit", 32'(cpu_hit), 32'd1);
    checkOutput("t2_c3_mem_req", 32'(mem_req), 32'd0);
    checkOutput("t2_c3_rewrite_tag", 32'(rewrite_tag), 32'd0);
    @(negedge clk); #1;
    checkOutput("t2_idle_cpu_ready", 32'(cpu_ready), 32'd0);

    // 3: write hit on channel 3 (tag 3, index 9), request held high for back-to-back
    @(negedge clk); applyStimulus(1'b1, 1'b1, 14'h624); is_hit = 1'b1; channel = 2'd3; #1;
    @(negedge clk); applyStimulus(1'b1, 1'b1, 14'h3FFF); #1;
    checkOutput("t3_lookup_tag", 32'(tag_o), 32'd3);
    checkOutput("t3_lookup_index", 32'(index_o), 32'd9);
    @(negedge clk); #1;
    checkOutput("t3_check_data_we", 32'(data_we), 32'd1);
    checkOutput("t3_check_data_channel", 32'(data_channel), 32'd3);
    checkOutput("t3_check_tag_stable", 32'(tag_o), 32'd3);
    checkOutput("t3_check_rewrite_tag", 32'(rewrite_tag), 32'd0);
    @(negedge clk); #1;
    checkOutput("t3_respond_cpu_ready", 32'(cpu_ready), 32'd1);
    checkOutput("t3_respond_cpu_hit", 32'(cpu_hit), 32'd1);
    checkOutput("t3_respond_data_we", 32'(data_we), 32'd0);
    checkOutput("t3_respond_rewrite_tag", 32'(rewrite_tag), 32'd0);
    @(negedge clk); #1;
    checkOutput("t3_gap_cpu_ready", 32'(cpu_ready), 32'd0);
    @(negedge clk); applyStimulus(1'b0, 1'b0, 14'h000); #1;
    checkOutput("t3b_lookup_tag", 32'(tag_o), 32'h1F);
    checkOutput("t3b_lookup_index", 32'(index_o), 32'h7F);
    @(negedge clk); #1;
    checkOutput("t3b_check_data_we", 32'(data_we), 32'd1);
    @(negedge clk); #1;
    checkOutput("t3b_respond_cpu_ready", 32'(cpu_ready), 32'd1);
    @(negedge clk); #1;

    // 4: full set, flush victim way 2 (tag 00110) before filling tag 9 index 5
    @(negedge clk); applyStimulus(1'b1, 1'b0, 14'h1216);
    is_hit = 1'b0; need_use_fifo = 1'b1; fifo_channel = 2'd2; fifo_tag_for_flush = 5'b00110; #1;
    @(negedge clk); applyStimulus(1'b0, 1'b0, 14'h1216); #1;
    @(negedge clk); #1;
    checkOutput("t4_check_mem_req", 32'(mem_req), 32'd0);
    @(negedge clk); mem_ack = 1'b1; fifo_channel = 2'd1; fifo_tag_for_flush = 5'b11111; #1;
    checkOutput("t4_flush_mem_req", 32'(mem_req), 32'd1);
    checkOutput("t4_flush_mem_we", 32'(mem_we), 32'd1);
    checkOutput("t4_flush_mem_addr", 32'(mem_addr), 32'hC14);
    checkOutput("t4_flush_data_we", 32'(data_we), 32'd0);
    @(negedge clk); mem_ack = 1'b0; #1;
    checkOutput("t4_fill_mem_req", 32'(mem_req), 32'd1);
    checkOutput("t4_fill_mem_we", 32'(mem_we), 32'd0);
    checkOutput("t4_fill_mem_addr", 32'(mem_addr), 32'h1214);
`ifdef CACHE_CTRL_STATS_EN
    checkOutput("t4_flush_count", 32'(flush_count), 32'd1);
`else
    checkOutput("t4_flush_count", 32'(flush_count), 32'd0);
`endif
    @(negedge clk); mem_ack = 1'b1; #1;
    checkOutput("t4_ack_data_we", 32'(data_we), 32'd1);
    checkOutput("t4_ack_data_channel", 32'(data_channel), 32'd2);
    @(negedge clk); mem_ack = 1'b0; #1;
    checkOutput("t4_update_rewrite_tag", 32'(rewrite_tag), 32'd1);
    checkOutput("t4_update_data_we", 32'(data_we), 32'd0);
    checkOutput("t4_update_mem_req", 32'(mem_req), 32'd0);
    @(negedge clk); #1;
    checkOutput("t4_respond_cpu_ready", 32'(cpu_ready), 32'd1);
    checkOutput("t4_respond_cpu_hit", 32'(cpu_hit), 32'd0);
    @(negedge clk); #1;
`ifdef CACHE_CTRL_STATS_EN
    checkOutput("t4_hit_count", 32'(hit_count), 32'd3);
    checkOutput("t4_miss_count", 32'(miss_count), 32'd2);
`else
    checkOutput("t4_hit_count", 32'(hit_count), 32'd0);
    checkOutput("t4_miss_count", 32'(miss_count), 32'd0);
`endif

    // 5: reset in the 2nd FILL cycle; a late mem_ack must be ignored
    @(negedge clk); applyStimulus(1'b1, 1'b0, 14'h40C); is_hit = 1'b0; need_use_fifo = 1'b0; #1;
    @(negedge clk); applyStimulus(1'b0, 1'b0, 14'h40C); #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checkOutput("t5_fill_mem_req", 32'(mem_req), 32'd1);
    checkOutput("t5_fill_mem_addr", 32'(mem_addr), 32'h40C);
    @(negedge clk); reset = 1'b1; #1;
    checkOutput("t5_fill2_mem_req", 32'(mem_req), 32'd1);
    @(negedge clk); reset = 1'b0; mem_ack = 1'b1; #1;
    checkQuiet("t5_after_reset");
    @(negedge clk); mem_ack = 1'b0; #1;
    checkOutput("t5_late_ack_data_we", 32'(data_we), 32'd0);
    checkOutput("t5_late_ack_rewrite_tag", 32'(rewrite_tag), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checkOutput("t5_no_cpu_ready", 32'(cpu_ready), 32'd0);
      checkOutput("t5_no_mem_req", 32'(mem_req), 32'd0);
    end

`ifdef CACHE_CTRL_STATS_EN
    // 6: hit_count saturates at 16'hFFFF
    for (int i = 0; i < 65535; i++) doHit();
    #1;
    checkOutput("t6_hit_count_full", 32'(hit_count), 32'hFFFF);
    doHit();
    #1;
    checkOutput("t6_hit_count_saturated", 32'(hit_count), 32'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
